// File: rtl/prng_pkg.sv
// prng_pkg: FSM states, width limit and single-step LFSR helper shared by prng_lfsr_stream.
// Operands are carried at PRNG_MAX_WIDTH; callers zero-extend and keep the low WIDTH bits.
package prng_pkg;

  localparam int PRNG_MAX_WIDTH = 128;

  typedef enum logic [0:0] {
    PRNG_IDLE = 1'b0,
    PRNG_RUN  = 1'b1
  } prng_fsm_e;

  typedef logic [PRNG_MAX_WIDTH-1:0] prng_word_t;

  // One Fibonacci shift: feedback is the parity of the tapped state bits.
  function automatic prng_word_t lfsr_step(input prng_word_t state, input prng_word_t poly);
    return {state[PRNG_MAX_WIDTH-2:0], ^(state & poly)};
  endfunction

endpackage

// File: rtl/prng_word_fifo.sv
// prng_word_fifo: synchronous WIDTH x DEPTH word buffer with flush, count and zeroed head when empty.
// DEPTH is a power of two so read/write pointers wrap by natural overflow.
module prng_word_fifo
  import prng_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [WIDTH-1:0]           i_data,
  output logic                       o_valid,
  output logic                       o_full,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic [WIDTH-1:0]           o_head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_empty;
  logic             w_do_pop;
  logic             w_do_push;

  assign w_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign o_valid   = !w_empty;
  assign o_count   = r_count;
  assign o_head    = w_empty ? '0 : r_mem[r_rd_ptr];

  // A push into a full buffer is only allowed when the head leaves on the same edge.
  assign w_do_pop  = i_pop && !w_empty && !i_flush;
  assign w_do_push = i_push && !i_flush && (!o_full || w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/prng_lfsr_stream.sv
// prng_lfsr_stream: Fibonacci LFSR word generator (STEP shifts per word) feeding a valid/ready buffer.
// Optional zero-state guard enabled by defining PRNG_LOCKUP_GUARD_EN.
//
//   state     | meaning
//   PRNG_IDLE | unseeded after reset; nothing generated until seed_load
//   PRNG_RUN  | generating one word per cycle whenever the buffer can take it
module prng_lfsr_stream
  import prng_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int STEP  = 1,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       seed_load,
  input  logic [WIDTH-1:0]           seed,
  input  logic [WIDTH-1:0]           poly,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       seeded,
  output logic [$clog2(DEPTH+1)-1:0] fill_level,
  output logic                       lockup_event
);

  localparam prng_word_t WORD_MASK = {PRNG_MAX_WIDTH{1'b1}} >> (PRNG_MAX_WIDTH - WIDTH);

  prng_fsm_e        r_fsm;
  prng_fsm_e        w_fsm_nxt;
  logic [WIDTH-1:0] r_state;
  logic [WIDTH-1:0] r_poly;
  logic [WIDTH-1:0] w_seed_eff;
  logic [WIDTH-1:0] w_gen_base;
  logic [WIDTH-1:0] w_gen_word;
  prng_word_t       w_acc;
  logic             w_run;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_fifo_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_fsm <= PRNG_IDLE;
    else        r_fsm <= w_fsm_nxt;
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      PRNG_IDLE: if (seed_load) w_fsm_nxt = PRNG_RUN;
      PRNG_RUN:  w_fsm_nxt = PRNG_RUN;
      default:   w_fsm_nxt = PRNG_IDLE;
    endcase
  end

  // seed_load wins over both handshake directions; the word popped that cycle is dropped.
  always_comb begin
    w_run  = (r_fsm == PRNG_RUN);
    seeded = w_run;
    w_pop  = w_fifo_valid && out_ready && !seed_load;
    w_push = w_run && !seed_load && (!w_full || w_pop);
  end

  always_comb begin
    w_acc = PRNG_MAX_WIDTH'(w_gen_base);
    for (int i = 0; i < STEP; i++) begin
      w_acc = lfsr_step(w_acc, PRNG_MAX_WIDTH'(r_poly)) & WORD_MASK;
    end
    w_gen_word = w_acc[WIDTH-1:0];
  end

`ifdef PRNG_LOCKUP_GUARD_EN
  logic w_zero_state;
  logic r_lockup;

  assign w_zero_state = (r_state == '0);
  assign w_gen_base   = w_zero_state ? WIDTH'(1) : r_state;
  assign w_seed_eff   = (seed == '0) ? WIDTH'(1) : seed;
  assign lockup_event = r_lockup;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_lockup <= 1'b0;
    else if (seed_load) r_lockup <= (seed == '0);
    else                r_lockup <= w_push && w_zero_state;
  end
`else
  assign w_gen_base   = r_state;
  assign w_seed_eff   = seed;
  assign lockup_event = 1'b0;
`endif

  // poly is captured only at seed time so later bus changes cannot alter the sequence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= '0;
      r_poly  <= '0;
    end else if (seed_load) begin
      r_state <= w_seed_eff;
      r_poly  <= poly;
    end else if (w_push) begin
      r_state <= w_gen_word;
    end
  end

  prng_word_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (seed_load),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_gen_word),
    .o_valid (w_fifo_valid),
    .o_full  (w_full),
    .o_count (fill_level),
    .o_head  (out_data)
  );

  assign out_valid = w_fifo_valid;

endmodule

// File: tb/tb_prng_lfsr_stream.sv
// Bench for prng_lfsr_stream: two 8-bit instances (STEP=1 and STEP=4) on shared stimulus,
// checked every cycle against a queue-based model plus hand-computed literal words.
module tb_prng_lfsr_stream;

  localparam int W     = 8;
  localparam int DEPTH = 4;
`ifdef PRNG_LOCKUP_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         seed_load = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] seed = '0;
  logic [W-1:0] poly = '0;

  logic         v1, v4, s1, s4, l1, l4;
  logic [W-1:0] d1, d4;
  logic [2:0]   f1, f4;

  always #5 clk = ~clk;

  prng_lfsr_stream #(.WIDTH(W), .STEP(1), .DEPTH(DEPTH)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed(seed), .poly(poly),
    .out_valid(v1), .out_ready(out_ready), .out_data(d1), .seeded(s1),
    .fill_level(f1), .lockup_event(l1)
  );

  prng_lfsr_stream #(.WIDTH(W), .STEP(4), .DEPTH(DEPTH)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed(seed), .poly(poly),
    .out_valid(v4), .out_ready(out_ready), .out_data(d4), .seeded(s4),
    .fill_level(f4), .lockup_event(l4)
  );

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: n shifts, each doubling the state and adding the tap parity.
  function automatic logic [W-1:0] advance(input logic [W-1:0] s, input logic [W-1:0] p, input int n);
    logic [W-1:0] x;
    x = s;
    for (int i = 0; i < n; i++) x = W'(x << 1) | W'($countones(x & p) % 2);
    return x;
  endfunction

  bit           m_run = 1'b0;
  bit           m_pop;
  bit           m_lk1 = 1'b0;
  bit           m_lk4 = 1'b0;
  logic [W-1:0] m_st1 = '0;
  logic [W-1:0] m_st4 = '0;
  logic [W-1:0] m_pq  = '0;
  logic [W-1:0] m_b;
  logic [W-1:0] q1[$];
  logic [W-1:0] q4[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 1'b0; m_st1 = '0; m_st4 = '0; m_pq = '0;
      m_lk1 = 1'b0; m_lk4 = 1'b0;
      q1.delete(); q4.delete();
    end else begin
      m_lk1 = 1'b0;
      m_lk4 = 1'b0;
      if (seed_load) begin
        q1.delete(); q4.delete();
        m_run = 1'b1;
        m_pq  = poly;
        m_st1 = seed;
        if (GUARD && seed == '0) begin
          m_st1 = 1; m_lk1 = 1'b1; m_lk4 = 1'b1;
        end
        m_st4 = m_st1;
      end else if (m_run) begin
        m_pop = (q1.size() > 0) && out_ready;
        if (m_pop) begin
          void'(q1.pop_front());
          void'(q4.pop_front());
        end
        if (q1.size() < DEPTH) begin
          m_b = m_st1;
          if (GUARD && m_b == '0) begin m_b = 1; m_lk1 = 1'b1; end
          m_st1 = advance(m_b, m_pq, 1);
          q1.push_back(m_st1);
          m_b = m_st4;
          if (GUARD && m_b == '0) begin m_b = 1; m_lk4 = 1'b1; end
          m_st4 = advance(m_b, m_pq, 4);
          q4.push_back(m_st4);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("valid1",  v1, q1.size() > 0);
      chk("data1",   d1, (q1.size() > 0) ? q1[0] : 8'h00);
      chk("fill1",   f1, q1.size());
      chk("seeded1", s1, m_run);
      chk("lock1",   l1, m_lk1);
      chk("valid4",  v4, q4.size() > 0);
      chk("data4",   d4, (q4.size() > 0) ? q4[0] : 8'h00);
      chk("fill4",   f4, q4.size());
      chk("seeded4", s4, m_run);
      chk("lock4",   l4, m_lk4);
    end
  end

  // With taps 8'h80 the register behaves as a one-hot rotation.
  logic [W-1:0] rot [8] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};

  initial begin
    #1 rst_n = 1'b0;
    cmp_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_valid", v1, 0); chk("rst_data", d1, 0); chk("rst_fill", f1, 0);
    chk("rst_seeded", s1, 0); chk("rst_lock", l1, 0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_valid", v1, 0); chk("idle_seeded", s1, 0);

    // Free-running stream, STEP=1 and STEP=4.
    seed = 8'h01; poly = 8'h80; seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    chk("load_valid_t1", v1, 0); chk("load_seeded_t1", s1, 1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("stream_valid", v1, 1);
      chk("stream_word", d1, rot[k]);
      if (k == 0) chk("step4_word0", d4, 8'h10);
      if (k == 1) chk("step4_word1", d4, 8'h01);
    end

    // Backpressure until full, then drain with no gaps.
    seed = 8'h01; poly = 8'h80; seed_load = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    seed_load = 1'b0;
    repeat (6) @(negedge clk);
    chk("full_fill", f1, 4); chk("full_head", d1, 8'h02);
    out_ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      @(negedge clk);
      chk("drain_word", d1, rot[k]);
      chk("drain_fill", f1, 4);
    end

    // Reseed while full and popping.
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_reseed_fill", f1, 4);
    seed = 8'h40; seed_load = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    chk("reseed_fill", f1, 0); chk("reseed_valid", v1, 0);
    @(negedge clk);
    chk("reseed_word", d1, 8'h80);
    repeat (3) @(negedge clk);

    // Zero seed.
    seed = 8'h00; poly = 8'hB8; seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    chk("zero_lock", l1, GUARD);
    @(negedge clk);
    chk("zero_word", d1, GUARD ? 8'h02 : 8'h00);
    chk("zero_lock_after", l1, 0);
    repeat (4) @(negedge clk);

    // Empty tap mask: the seed shifts out and the state goes to zero.
    seed = 8'h80; poly = 8'h00; seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    @(negedge clk);
    chk("poly0_word", d1, 8'h00);
    repeat (6) @(negedge clk);

    // Asynchronous reset mid-stream.
    seed = 8'h01; poly = 8'hB8; seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", v1, 0); chk("arst_data", d1, 0); chk("arst_fill", f1, 0);
    chk("arst_seeded", s1, 0); chk("arst_data4", d4, 0); chk("arst_lock", l1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_arst_valid", v1, 0); chk("post_arst_seeded", s1, 0);

    // Randomised traffic: sparse reseeds, varied ready duty cycle.
    for (int c = 0; c < 600; c++) begin
      seed_load = ($urandom_range(0, 31) == 0) || (c == 0);
      if (seed_load) begin
        seed = ($urandom_range(0, 4) == 0) ? 8'h00 : W'($urandom);
        poly = ($urandom_range(0, 5) == 0) ? 8'h00 : W'($urandom);
      end
      if (c < 300) out_ready = ($urandom_range(0, 3) == 0);
      else         out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end
    seed_load = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
